// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: data widths, reset PC default and
// the fetch FSM state type.
package riscv_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry output buffer between instruction memory and decode; a flush
// empties it in one cycle and takes priority over push/pop.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int W = XLEN + INSTR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         rd_q, rd_d;
   logic         wr_q, wr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         do_push, do_pop;

   assign do_pop  = pop_i && (cnt_q != 2'd0);
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

   always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         rd_d  = 1'b0;
         wr_d  = 1'b0;
         cnt_d = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = !wr_q;
         end
         if (do_pop) begin
            rd_d = !rd_q;
         end
         cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   assign valid_o = (cnt_q != 2'd0);
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word requests from the fetch PC under a credit
// limit, matches in-order responses to their PCs and drops responses made stale by a redirect.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_i,
   input  logic [XLEN-1:0]    redirect_pc_i,
   output logic               imem_req_o,
   output logic [XLEN-1:0]    imem_addr_o,
   input  logic               imem_gnt_i,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic               if_valid_o,
   output logic [INSTR_W-1:0] if_instr_o,
   output logic [XLEN-1:0]    if_pc_o,
   input  logic               if_ready_i,
   output fetch_state_t       dbg_state_o
);

   // Handshakes: a request transfers when imem_req_o && imem_gnt_i, and once
   // raised it holds with a stable address until granted or redirected; an
   // instruction transfers to decode when if_valid_o && if_ready_i.

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 2);
   localparam int OCC_W = CNT_W + 1;

   fetch_state_t      state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  cnt_pop;
   logic [XLEN-1:0]   aq_q [MAX_OUTSTANDING];
   logic [XLEN-1:0]   aq_d [MAX_OUTSTANDING];
   logic              req_hold_q, req_hold_d;
   logic              gnt_fire, rv_live, rv_stale, rv_any, xfer, credit_ok;
   logic              fifo_push;
   logic [1:0]        fifo_cnt;
   logic [OCC_W-1:0]  occ;
   logic [XLEN+INSTR_W-1:0] fifo_head;

   assign xfer     = if_valid_o && if_ready_i;
   // An entry leaving the buffer this cycle frees its credit immediately, so
   // a steady stream sustains one fetch per cycle.
   assign occ       = OCC_W'(out_cnt_q) + OCC_W'(fifo_cnt) - OCC_W'(xfer);
   assign credit_ok = (occ < OCC_W'(MAX_OUTSTANDING));

   assign imem_req_o  = !rst && (state_q == RUN) && (req_hold_q || credit_ok);
   assign imem_addr_o = pc_q;
   assign gnt_fire    = imem_req_o && imem_gnt_i;

   assign rv_stale  = imem_rvalid_i && (drop_q != '0);
   assign rv_live   = imem_rvalid_i && (drop_q == '0) && (out_cnt_q != '0);
   assign rv_any    = rv_stale || rv_live;
   assign fifo_push = rv_live && !redirect_i;

   always_comb begin
      pc_d       = pc_q;
      out_cnt_d  = out_cnt_q;
      drop_d     = drop_q;
      aq_d       = aq_q;
      state_d    = state_q;
      req_hold_d = imem_req_o && !imem_gnt_i && !redirect_i;
      cnt_pop    = out_cnt_q - CNT_W'(rv_live);

      if (rv_live) begin
         for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
            aq_d[i] = aq_q[i + 1];
         end
      end

      if (redirect_i) begin
         // Everything in flight, including a grant taken this very cycle,
         // belongs to the old path and must be swallowed on return.
         pc_d      = word_align(redirect_pc_i);
         out_cnt_d = '0;
         drop_d    = drop_q + out_cnt_q + CNT_W'(gnt_fire) - CNT_W'(rv_any);
      end else begin
         if (gnt_fire) begin
            pc_d = pc_q + 32'd4;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
               if (CNT_W'(i) == cnt_pop) begin
                  aq_d[i] = pc_q;
               end
            end
         end
         out_cnt_d = cnt_pop + CNT_W'(gnt_fire);
         drop_d    = drop_q - CNT_W'(rv_stale);
      end

      case (state_q)
         RUN:     if (drop_d != '0) state_d = FLUSH;
         FLUSH:   if (drop_d == '0) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= word_align(RESET_PC);
         out_cnt_q  <= '0;
         drop_q     <= '0;
         req_hold_q <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            aq_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_q     <= drop_d;
         req_hold_q <= req_hold_d;
         aq_q       <= aq_d;
      end
   end

   fetch_fifo #(
      .W(XLEN + INSTR_W)
   ) u_fetch_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_i),
      .push_i  (fifo_push),
      .data_i  ({aq_q[0], imem_rdata_i}),
      .pop_i   (xfer),
      .valid_o (if_valid_o),
      .data_o  (fifo_head),
      .count_o (fifo_cnt)
   );

   assign if_pc_o     = fifo_head[XLEN+INSTR_W-1 -: XLEN];
   assign if_instr_o  = fifo_head[INSTR_W-1:0];
   assign dbg_state_o = state_q;

endmodule
